// File: rtl/prog_clock_divider.sv
// Programmable clock divider with square or pulse output, a deferred divisor/mode
// update, and a period restart input.
module prog_clock_divider #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned RST_DIV  = 10,
  parameter bit          RST_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             mode_in,
  output logic             div_clk,
  output logic             tick,
  output logic             upd_pend,
  output logic             load_err,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_ff, count_nxt, count_inc;
  logic [WIDTH-1:0] div_q, div_nxt;
  logic [WIDTH-1:0] pend_div, pend_div_nxt;
  logic             mode_q, mode_nxt;
  logic             pend_mode, pend_mode_nxt;
  logic             pend_nxt, div_clk_nxt, tick_nxt, load_err_nxt;
  logic             wrap, restart, load_ok;

  assign count     = count_ff;
  assign count_inc = count_ff + WIDTH'(1);
  assign wrap      = en && (count_ff == (div_q - WIDTH'(1)));
  assign restart   = clr || wrap;
  assign load_ok   = load && (div_in >= WIDTH'(2));

  // Next-state: a restart starts a new period and applies any new configuration
  always_comb begin
    count_nxt     = count_ff;
    div_clk_nxt   = div_clk;
    tick_nxt      = 1'b0;
    div_nxt       = div_q;
    mode_nxt      = mode_q;
    pend_div_nxt  = pend_div;
    pend_mode_nxt = pend_mode;
    pend_nxt      = upd_pend;
    load_err_nxt  = load && !load_ok;

    if (restart) begin
      count_nxt   = '0;
      tick_nxt    = 1'b1;
      div_clk_nxt = 1'b0;
      pend_nxt    = 1'b0;
      if (load_ok) begin
        div_nxt  = div_in;
        mode_nxt = mode_in;
      end else if (upd_pend) begin
        div_nxt  = pend_div;
        mode_nxt = pend_mode;
      end
    end else begin
      if (en) begin
        count_nxt   = count_inc;
        div_clk_nxt = mode_q ? (count_inc == (div_q - WIDTH'(1)))
                             : (count_inc >= (div_q >> 1));
      end
      if (load_ok) begin
        pend_div_nxt  = div_in;
        pend_mode_nxt = mode_in;
        pend_nxt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_ff  <= '0;
      div_clk   <= 1'b0;
      tick      <= 1'b0;
      upd_pend  <= 1'b0;
      load_err  <= 1'b0;
      div_q     <= WIDTH'(RST_DIV);
      mode_q    <= RST_MODE;
      pend_div  <= '0;
      pend_mode <= 1'b0;
    end else begin
      count_ff  <= count_nxt;
      div_clk   <= div_clk_nxt;
      tick      <= tick_nxt;
      upd_pend  <= pend_nxt;
      load_err  <= load_err_nxt;
      div_q     <= div_nxt;
      mode_q    <= mode_nxt;
      pend_div  <= pend_div_nxt;
      pend_mode <= pend_mode_nxt;
    end
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Randomized bench for prog_clock_divider against a period-level reference model.
module tb_prog_clock_divider;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned RST_DIV = 10;

  logic             clk, rst_n, en, clr, load, mode_in;
  logic [WIDTH-1:0] div_in;
  logic             div_clk, tick, upd_pend, load_err;
  logic [WIDTH-1:0] count;

  int tests, errors;

  // Reference model: phase within period, active and queued configuration
  int m_cnt, m_div, m_mode, m_pdiv, m_pmode;
  bit m_pend, m_tick, m_err;

  prog_clock_divider #(.WIDTH(WIDTH), .RST_DIV(RST_DIV), .RST_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .div_in(div_in), .mode_in(mode_in), .div_clk(div_clk), .tick(tick),
    .upd_pend(upd_pend), .load_err(load_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit clk_of(int c, int d, int md);
    return (md != 0) ? (c == d - 1) : (c >= d / 2);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_div = RST_DIV; m_mode = 0; m_pend = 0; m_tick = 0; m_err = 0;
    m_pdiv = 0; m_pmode = 0;
  endtask

  task automatic model_step();
    bit legal, restart;
    legal   = load && (int'(div_in) >= 2);
    restart = clr || (en && m_cnt == m_div - 1);
    m_err   = load && !legal;
    m_tick  = restart;
    if (restart) begin
      if (legal) begin
        m_div = int'(div_in); m_mode = int'(mode_in);
      end else if (m_pend) begin
        m_div = m_pdiv; m_mode = m_pmode;
      end
      m_pend = 0;
      m_cnt  = 0;
    end else begin
      if (en) m_cnt++;
      if (legal) begin
        m_pdiv = int'(div_in); m_pmode = int'(mode_in); m_pend = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(m_cnt));
    chk("div_clk", 32'(div_clk), 32'(clk_of(m_cnt, m_div, m_mode)));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("upd_pend", 32'(upd_pend), 32'(m_pend));
    chk("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int first_tick, second_tick;
    tests = 0; errors = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; div_in = '0; mode_in = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Default configuration, free running: ticks every 10 cycles after the first wrap
    en = 1'b1;
    first_tick = -1; second_tick = -1;
    for (int i = 1; i <= 25; i++) begin
      cycle();
      if (tick && first_tick < 0) first_tick = i;
      else if (tick && second_tick < 0) second_tick = i;
    end
    chk("first_tick_cycle", 32'(first_tick), 32'd10);
    chk("second_tick_cycle", 32'(second_tick), 32'd20);

    // Illegal loads are flagged and leave pending state alone
    load = 1'b1; div_in = 8'd1; cycle();
    load = 1'b0; cycle();
    load = 1'b1; div_in = 8'd0; cycle();
    load = 1'b0; cycle();

    // Randomized traffic with occasional mid-cycle asynchronous reset
    for (int i = 0; i < 4000; i++) begin
      en      = ($urandom % 10) != 0;
      clr     = ($urandom % 40) == 0;
      load    = ($urandom % 8) == 0;
      div_in  = (($urandom % 16) == 0) ? WIDTH'($urandom_range(0, 40))
                                       : WIDTH'($urandom_range(0, 12));
      mode_in = 1'($urandom % 2);
      if (($urandom % 400) == 0) begin
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
